// File: rtl/cla_pipe_addsub_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | cla_pipe_addsub_if : operand/result handshake bundle for cla_pipe_addsub
// | rev 1.0
// +-----------------------------------------------------------------------------
interface cla_pipe_addsub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface
`default_nettype wire

// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | cla_pipe_addsub : pipelined CLA add/sub, one segment per stage; CLA_SAT_EN enables saturation
// | rev 1.0
// +-----------------------------------------------------------------------------
module cla_pipe_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2,
   parameter int GROUP  = 4
) (
   input logic               clk,
   input logic               rst,
   cla_pipe_addsub_if.slave  io
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int NGRP = SEG / GROUP;
   localparam int LAST = STAGES - 1;

   logic             stall;
   logic             advance;
   logic             out_valid_w;
   logic [WIDTH-1:0] raw_sum;
   logic [WIDTH-1:0] sum_w;
   logic             a_sign;
   logic             b_sign;
   logic             ovf_w;

   // Group P/G lookahead across the segment, per-bit lookahead inside each group.
   function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                            input logic [SEG-1:0] y,
                                            input logic           cin);
      logic [SEG-1:0]  g;
      logic [SEG-1:0]  p;
      logic [SEG-1:0]  s;
      logic [NGRP-1:0] gg;
      logic [NGRP-1:0] gp;
      logic [NGRP:0]   gc;
      logic            gpre;
      logic            ppre;
      g = x & y;
      p = x ^ y;
      for (int k = 0; k < NGRP; k++) begin
         gg[k] = 1'b0;
         gp[k] = 1'b1;
         for (int i = 0; i < GROUP; i++) begin
            gg[k] = g[k*GROUP+i] | (p[k*GROUP+i] & gg[k]);
            gp[k] = gp[k] & p[k*GROUP+i];
         end
      end
      gc[0] = cin;
      for (int k = 0; k < NGRP; k++) begin
         gc[k+1] = gg[k] | (gp[k] & gc[k]);
      end
      for (int k = 0; k < NGRP; k++) begin
         for (int i = 0; i < GROUP; i++) begin
            gpre = 1'b0;
            ppre = 1'b1;
            for (int j = 0; j < i; j++) begin
               gpre = g[k*GROUP+j] | (p[k*GROUP+j] & gpre);
               ppre = ppre & p[k*GROUP+j];
            end
            s[k*GROUP+i] = p[k*GROUP+i] ^ (gpre | (ppre & gc[k]));
         end
      end
      return {gc[NGRP], s};
   endfunction

   assign out_valid_w = g_stage[LAST].valid_q;
   assign stall       = out_valid_w & ~io.out_ready;
   assign advance     = ~stall;

   // Stage gi keeps only the operand bits not yet consumed (skew) and the
   // finished low sum bits (deskew); the last stage keeps just the sign bits.
   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int BASE = gi * SEG;
      localparam int LO   = BASE + SEG;
      localparam int KEEP = (gi == LAST) ? WIDTH - 1 : LO;

      logic [WIDTH-1:BASE] a_in;
      logic [WIDTH-1:BASE] b_in;
      logic                c_in;
      logic                v_in;
      logic [SEG:0]        seg_res;
      logic                valid_d, valid_q;
      logic                carry_d, carry_q;
      logic [WIDTH-1:KEEP] a_d, a_q;
      logic [WIDTH-1:KEEP] b_d, b_q;
      logic [LO-1:0]       sum_d, sum_q;

      if (gi == 0) begin : g_head
         always_comb begin
            a_in  = io.a;
            b_in  = io.sub ? ~io.b : io.b;
            c_in  = io.sub;
            v_in  = io.in_valid;
            sum_d = seg_res[SEG-1:0];
         end
      end else begin : g_tail
         always_comb begin
            a_in  = g_stage[gi-1].a_q;
            b_in  = g_stage[gi-1].b_q;
            c_in  = g_stage[gi-1].carry_q;
            v_in  = g_stage[gi-1].valid_q;
            sum_d = {seg_res[SEG-1:0], g_stage[gi-1].sum_q};
         end
      end

      always_comb begin
         seg_res = cla_seg(a_in[BASE +: SEG], b_in[BASE +: SEG], c_in);
         a_d     = a_in[WIDTH-1:KEEP];
         b_d     = b_in[WIDTH-1:KEEP];
         carry_d = seg_res[SEG];
         valid_d = v_in;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
         end else if (advance) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
         end
      end
   end

   assign raw_sum = g_stage[LAST].sum_q;
   assign a_sign  = g_stage[LAST].a_q[WIDTH-1];
   assign b_sign  = g_stage[LAST].b_q[WIDTH-1];
   assign ovf_w   = (a_sign == b_sign) && (raw_sum[WIDTH-1] != a_sign);

`ifdef CLA_SAT_EN
   always_comb begin
      sum_w = raw_sum;
      if (ovf_w) begin
         sum_w = a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign sum_w = raw_sum;
`endif

   assign io.in_ready  = advance;
   assign io.out_valid = out_valid_w;
   assign io.sum       = sum_w;
   assign io.cout      = g_stage[LAST].carry_q;
   assign io.ovf       = ovf_w;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_addsub.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_cla_pipe_addsub : randomized self-checking bench against an arithmetic model
// | rev 1.0
// +-----------------------------------------------------------------------------
module tb_cla_pipe_addsub;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cla_pipe_addsub_if #(.WIDTH(W)) bus ();

   cla_pipe_addsub #(.WIDTH(W), .STAGES(2), .GROUP(4)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus.slave)
   );

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Signed/unsigned integer arithmetic on the full operand values.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int   sa, sb, ua, ub, r;
      res_t o;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      r  = s ? sa - sb : sa + sb;
      o.sum  = r[W-1:0];
      o.cout = s ? (ua >= ub) : (ua + ub > 65535);
      o.ovf  = (r > 32767) || (r < -32768);
`ifdef CLA_SAT_EN
      if (r > 32767)       o.sum = 16'h7FFF;
      else if (r < -32768) o.sum = 16'h8000;
`endif
      return o;
   endfunction

   function automatic logic [W-1:0] pick_operand();
      logic [W-1:0] sp [6];
      sp[0] = 16'h0000; sp[1] = 16'hFFFF; sp[2] = 16'h7FFF;
      sp[3] = 16'h8000; sp[4] = 16'h00FF; sp[5] = 16'h0001;
      if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
      return W'($urandom);
   endfunction

   task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] esum, input logic ecout,
                         input logic eovf);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.sub = s;
      #1 chk({tag, "_in_ready"}, bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 chk({tag, "_early_valid"}, bus.out_valid, 0);
      @(negedge clk);
      #1;
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_sum"},   bus.sum,  esum);
      chk({tag, "_cout"},  bus.cout, ecout);
      chk({tag, "_ovf"},   bus.ovf,  eovf);
      @(negedge clk);
      #1 chk({tag, "_no_dup"}, bus.out_valid, 0);
   endtask

   task automatic stream(input string tag, input int nops, input bit rnd);
      logic [W-1:0] oa [64];
      logic [W-1:0] ob [64];
      logic         os [64];
      res_t         exp_q [$];
      res_t         e;
      int           issued = 0, retired = 0, stalls = 0, k = 0;
      bit           was_stall = 0, st;
      logic [W-1:0] h_sum;
      logic         h_cout, h_ovf;
      for (int i = 0; i < nops; i++) begin
         oa[i] = pick_operand();
         ob[i] = pick_operand();
         os[i] = 1'($urandom_range(0, 1));
      end
      while (retired < nops && k < 600) begin
         @(negedge clk);
         bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(k >= 4 && k < 7);
         if (issued < nops && (!rnd || $urandom_range(0, 4) != 0)) begin
            bus.in_valid = 1'b1; bus.a = oa[issued]; bus.b = ob[issued]; bus.sub = os[issued];
         end else begin
            bus.in_valid = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom);
         end
         #1;
         st = bus.out_valid && !bus.out_ready;
         chk({tag, "_in_ready"}, bus.in_ready, !st);
         if (was_stall) begin
            chk({tag, "_hold_valid"}, bus.out_valid, 1);
            chk({tag, "_hold_sum"},   bus.sum,  h_sum);
            chk({tag, "_hold_cout"},  bus.cout, h_cout);
            chk({tag, "_hold_ovf"},   bus.ovf,  h_ovf);
         end
         if (st) begin
            h_sum = bus.sum; h_cout = bus.cout; h_ovf = bus.ovf;
            stalls++;
         end
         was_stall = st;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk({tag, "_spurious"}, 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk({tag, "_sum"},  bus.sum,  e.sum);
               chk({tag, "_cout"}, bus.cout, e.cout);
               chk({tag, "_ovf"},  bus.ovf,  e.ovf);
            end
            retired++;
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.a, bus.b, bus.sub));
            issued++;
         end
         k++;
      end
      chk({tag, "_retired"}, retired, nops);
      if (!rnd) chk({tag, "_stall_cycles"}, stalls, 3);
      @(negedge clk);
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_sum",   bus.sum,  0);
      chk("rst_cout",  bus.cout, 0);
      chk("rst_ovf",   bus.ovf,  0);
      chk("rst_ready", bus.in_ready, 1);

      single("inc",      16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0);
      single("seg_cry",  16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
      single("wrap",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef CLA_SAT_EN
      single("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      single("neg_ovf",  16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
      single("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      single("neg_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
      single("sub_zero", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0);
      single("borrow",   16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);

      stream("bp", 8, 1'b0);
      stream("rnd", 40, 1'b1);

      // Two ops in flight, then a single reset cycle.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = 16'h7FFF; bus.b = 16'h0001; bus.sub = 1'b0;
      @(negedge clk);
      bus.a = 16'hFFFF; bus.b = 16'h0001;
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_valid", bus.out_valid, 0);
      chk("mrst_sum",   bus.sum,  0);
      chk("mrst_cout",  bus.cout, 0);
      chk("mrst_ovf",   bus.ovf,  0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1 chk("mrst_stale", bus.out_valid, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
